button_events: RTL and testbench

Converts the clean, debounced push-button level produced by the stopwatch's debounce stage into discrete single-cycle events: press, release, click (short press), long press and auto-repeat. It sits between the debounced button lines and the stopwatch control FSM, one instance per button, so the controller never deals with levels or hold durations.

---
 rtl/button_events_if.sv | 21 ++
 rtl/button_events.sv | 103 ++++++++++
 tb/tb_button_events.sv | 121 ++++++++++++
 3 files changed

// File: rtl/button_events_if.sv
// Button level in, single-cycle button events out; one bundle per button.
// The release/repeat events carry an _evt suffix because the bare names are SV keywords.
interface button_events_if;
    logic btn;
    logic press;
    logic release_evt;
    logic click;
    logic long_press;
    logic repeat_evt;
    logic held;

    modport master (
        output btn,
        input  press, release_evt, click, long_press, repeat_evt, held
    );

    modport slave (
        input  btn,
        output press, release_evt, click, long_press, repeat_evt, held
    );
endinterface

// File: rtl/button_events.sv
// Turns a debounced button level into press/release/click/long-press/auto-repeat pulses.
// Latency: 1 cycle from btn sampled to registered event; all outputs registered.
// Backpressure: none, events are fire-and-forget single-cycle pulses.
module button_events #(
    parameter int unsigned CLK_FREQ_KHZ = 100_000,
    parameter int unsigned LONG_MS      = 1000,
    parameter int unsigned REPEAT_MS    = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    button_events_if.slave   bif
);
    localparam logic [31:0] LONG_CYC   = 32'(CLK_FREQ_KHZ * LONG_MS);
    localparam logic [31:0] REPEAT_CYC = 32'(CLK_FREQ_KHZ * REPEAT_MS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        btn_q;
    logic [31:0] cnt, cnt_nxt;
    logic        rise, fall;
    logic        press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

    assign rise = bif.btn & ~btn_q;
    assign fall = ~bif.btn & btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            btn_q           <= 1'b0;
            cnt             <= '0;
            bif.press       <= 1'b0;
            bif.release_evt <= 1'b0;
            bif.click       <= 1'b0;
            bif.long_press  <= 1'b0;
            bif.repeat_evt  <= 1'b0;
            bif.held        <= 1'b0;
        end else begin
            state           <= state_nxt;
            btn_q           <= bif.btn;
            cnt             <= cnt_nxt;
            bif.press       <= press_nxt;
            bif.release_evt <= release_nxt;
            bif.click       <= click_nxt;
            bif.long_press  <= long_nxt;
            bif.repeat_evt  <= repeat_nxt;
            bif.held        <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        click_nxt   = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                cnt_nxt = cnt + 32'd1;
                // A release on the threshold cycle still counts as a click.
                if (fall) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                    click_nxt   = 1'b1;
                end else if (cnt == LONG_CYC - 32'd1) begin
                    state_nxt = ST_REPEAT;
                    cnt_nxt   = '0;
                    long_nxt  = 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_nxt   = ST_IDLE;
                    release_nxt = 1'b1;
                end else if ((REPEAT_CYC != 32'd0) && (cnt == REPEAT_CYC - 32'd1)) begin
                    repeat_nxt = 1'b1;
                    cnt_nxt    = '0;
                end else if (cnt != 32'hFFFF_FFFF) begin
                    // With repeat disabled this saturates instead of wrapping.
                    cnt_nxt = cnt + 32'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_button_events.sv
// Directed bench: two instances (repeat 10 cycles / repeat disabled) share the same button stimulus.
module tb_button_events;
    localparam int LONG = 20;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    button_events_if if0 ();
    button_events_if if1 ();

    button_events #(.CLK_FREQ_KHZ(10), .LONG_MS(2), .REPEAT_MS(1)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (if0)
    );

    button_events #(.CLK_FREQ_KHZ(10), .LONG_MS(2), .REPEAT_MS(0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: {press, release, click, long_press, repeat, held}
    function automatic logic [5:0] ev_vec(input int sel);
        if (sel == 0)
            return {if0.press, if0.release_evt, if0.click, if0.long_press, if0.repeat_evt, if0.held};
        else
            return {if1.press, if1.release_evt, if1.click, if1.long_press, if1.repeat_evt, if1.held};
    endfunction

    // Expected events j cycles after the press edge, button high for hi edges.
    function automatic logic [5:0] exp_vec(input int j, input int hi, input int rep);
        logic p, r, c, l, rp, h;
        p  = (j == 0);
        r  = (j == hi);
        c  = (j == hi) && (hi <= LONG);
        l  = (j == LONG) && (j < hi);
        rp = (rep != 0) && (j > LONG) && (j < hi) && (((j - LONG) % rep) == 0);
        h  = (j < hi);
        return {p, r, c, l, rp, h};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (press,rel,click,long,rep,held)", tag, got, exp);
        end
    endtask

    task automatic set_btn(input logic b);
        if0.btn = b;
        if1.btn = b;
    endtask

    task automatic run_hold(input string tag, input int hi, input int total);
        for (int j = 0; j < total; j++) begin
            set_btn(j < hi);
            @(posedge clk);
            #1;
            check($sformatf("%s d0 c%0d", tag, j), ev_vec(0), exp_vec(j, hi, 10));
            check($sformatf("%s d1 c%0d", tag, j), ev_vec(1), exp_vec(j, hi, 0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_btn(1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("in_reset d0", ev_vec(0), 6'b0);
        check("in_reset d1", ev_vec(1), 6'b0);
        rst_n = 1'b1;

        for (int j = 0; j < 50; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("idle d0 c%0d", j), ev_vec(0), 6'b0);
            check($sformatf("idle d1 c%0d", j), ev_vec(1), 6'b0);
        end

        run_hold("short5", 5, 9);
        run_hold("hold45", 45, 49);
        run_hold("hold20", 20, 24);

        // Into REPEAT, then reset mid-cycle while the button stays down.
        run_hold("pre_rst", 100, 35);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst d0", ev_vec(0), 6'b0);
        check("async_rst d1", ev_vec(1), 6'b0);
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hold d0 c%0d", j), ev_vec(0), 6'b0);
            check($sformatf("rst_hold d1 c%0d", j), ev_vec(1), 6'b0);
        end
        rst_n = 1'b1;
        run_hold("post_rst", 25, 29);

        run_hold("hold60", 60, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
